dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory (DM) between two requesters: the pipelined core's MEM stage (cpu) and a debug/loader port (dbg). The dbg port preloads arrays (e.g. the sort array at 0x200) and dumps results without hierarchical peeking.
- Serialises accesses: one outstanding transaction at a time.
- Generates byte-lane enables and aligns write/read data for byte, half and word sizes.
- Detects misaligned accesses and applies a starvation guard so dbg always progresses while the core is running.

Parameters:
- ADDR_W, 32, address width of both requesters and memory.
- MAX_WAIT, 8, consecutive cycles dbg may be refused before it takes priority (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_req_valid  in  1  cpu request pending
- cpu_req_ready  out  1  cpu request accepted this cycle
- cpu_req_we  in  1  1=store, 0=load
- cpu_req_size  in  2  00 byte, 01 half, 10 word; 11 illegal
- cpu_req_addr  in  ADDR_W  byte address
- cpu_req_wdata  in  32  store data, right-justified
- cpu_rvalid  out  1  one-cycle response pulse
- cpu_rdata  out  32  load data, right-justified, zero-extended
- cpu_err  out  1  qualifies cpu_rvalid: misaligned or illegal size
- cpu_stall  out  1  cpu_req_valid & ~cpu_rvalid while cpu transaction not complete
- dbg_req_valid, dbg_req_ready, dbg_req_we, dbg_req_size, dbg_req_addr, dbg_req_wdata, dbg_rvalid, dbg_rdata, dbg_err  same widths/meaning as cpu_*
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_be  out  4  byte-lane enables
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  synchronous read data, valid one cycle after mem_en

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0; starvation counter 0; latched transaction discarded, no response issued for it.
- FSM IDLE -> ISSUE -> RESP -> IDLE. req_ready may be 1 only in IDLE, combinationally, to at most one requester.
- Arbitration in IDLE: cpu wins by default. dbg wins if it is the only requester, or if wait_cnt == MAX_WAIT.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle dbg_req_valid=1 and dbg is not granted. Clears on dbg grant or when dbg_req_valid=0.
- Accept at cycle T: latch owner, we, size, addr, wdata; go to ISSUE.
- Alignment check at accept: half needs addr[0]=0; word needs addr[1:0]=0; size 11 is illegal. On error, ISSUE keeps mem_en=0 and the response carries err=1, rdata=0.
- ISSUE (T+1): registered mem_en=1, mem_we=we, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111.
  - mem_wdata: byte replicated 4x; half replicated 2x; word unchanged.
- RESP (T+2): mem_en=0. rdata register = mem_rdata shifted right by 8*addr[1:0], masked to size. Writes return 0.
- T+3: owner's rvalid=1 for exactly one cycle with rdata/err; state is IDLE. A new request may be accepted in that same cycle.
- Latency: accept to rvalid = 3 cycles. Maximum throughput is 1 transaction per 3 cycles.
- rdata/err hold their last value until the next response.
- Requester rules: req fields must stay stable while valid=1 and ready=0; valid may drop without acceptance. Inputs are ignored outside IDLE.
- Simultaneous valid from both requesters with wait_cnt < MAX_WAIT: cpu granted, wait_cnt increments.

Test Plan:
- dbg stores word 0x00000009 @0x200, then loads it -> mem_be=1111, dbg_rvalid 3 cycles after each accept, dbg_rdata=0x00000009, dbg_err=0.
- cpu byte store 0xAB @0x203 -> mem_be=1000, mem_wdata=0xABABABAB. cpu half load @0x202 with mem_rdata=0xAB120000 -> cpu_rdata=0x0000AB12.
- cpu word load @0x206 -> mem_en never asserted, cpu_rvalid with cpu_err=1, cpu_rdata=0. Same result for size=11.
- cpu_req_valid held continuously and dbg_req_valid held (MAX_WAIT=8) -> dbg granted after 8 refused cycles, then cpu resumes. cpu_stall high throughout cpu waits.
- Both requesters valid in the same cycle, wait_cnt=0 -> cpu granted, dbg_req_ready=0. dbg is served in the next IDLE when cpu_req_valid=0.
- rst asserted during ISSUE -> all outputs 0 immediately. After release, no rvalid for the aborted access; next request completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with lane alignment and starvation guard
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [1:0]        cpu_req_size,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [31:0]       cpu_req_wdata,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic              dbg_req_we,
    input  logic [1:0]        dbg_req_size,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [31:0]       dbg_req_wdata,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t            r_state, w_next_state;
    logic [7:0]        r_wait_cnt;
    logic              r_own_dbg, r_we, r_err;
    logic [1:0]        r_size, r_off;
    logic              r_mem_en, r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_rvalid, r_dbg_rvalid, r_cpu_err, r_dbg_err;
    logic [31:0]       r_cpu_rdata, r_dbg_rdata;

    logic              w_idle, w_dbg_wins, w_grant_cpu, w_grant_dbg, w_accept;
    logic              w_sel_we, w_sel_err;
    logic [1:0]        w_sel_size;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata, w_wdata, w_shifted, w_masked, w_resp_data;
    logic [3:0]        w_be;

    // Readiness is gated by rst so nothing looks accepted while reset is held.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_dbg_wins  = dbg_req_valid && (!cpu_req_valid || (r_wait_cnt == LP_MAX_WAIT));
    assign w_grant_dbg = w_idle && w_dbg_wins;
    assign w_grant_cpu = w_idle && cpu_req_valid && !w_dbg_wins;
    assign w_accept    = w_grant_cpu || w_grant_dbg;

    assign w_sel_we    = w_grant_dbg ? dbg_req_we    : cpu_req_we;
    assign w_sel_size  = w_grant_dbg ? dbg_req_size  : cpu_req_size;
    assign w_sel_addr  = w_grant_dbg ? dbg_req_addr  : cpu_req_addr;
    assign w_sel_wdata = w_grant_dbg ? dbg_req_wdata : cpu_req_wdata;

    always_comb begin
        w_sel_err = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = w_sel_wdata;
        case (w_sel_size)
            2'b00: begin
                w_be    = 4'b0001 << w_sel_addr[1:0];
                w_wdata = {4{w_sel_wdata[7:0]}};
            end
            2'b01: begin
                w_sel_err = w_sel_addr[0];
                w_be      = w_sel_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{w_sel_wdata[15:0]}};
            end
            2'b10:   w_sel_err = |w_sel_addr[1:0];
            default: w_sel_err = 1'b1;
        endcase
    end

    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'b00:   w_masked = {24'd0, w_shifted[7:0]};
            2'b01:   w_masked = {16'd0, w_shifted[15:0]};
            default: w_masked = w_shifted;
        endcase
    end

    assign w_resp_data = (r_err || r_we) ? 32'd0 : w_masked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready = w_grant_cpu;
        dbg_req_ready = w_grant_dbg;
        cpu_stall     = cpu_req_valid && !r_cpu_rvalid && !rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt   <= 8'd0;
            r_own_dbg    <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_err    <= 1'b0;
            r_dbg_err    <= 1'b0;
            r_cpu_rdata  <= 32'd0;
            r_dbg_rdata  <= 32'd0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            if (dbg_req_valid && !w_grant_dbg)
                r_wait_cnt <= (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 8'd1;
            else
                r_wait_cnt <= 8'd0;
            if (w_accept) begin
                r_own_dbg   <= w_grant_dbg;
                r_we        <= w_sel_we;
                r_err       <= w_sel_err;
                r_size      <= w_sel_size;
                r_off       <= w_sel_addr[1:0];
                r_mem_en    <= !w_sel_err;
                r_mem_we    <= w_sel_we && !w_sel_err;
                r_mem_be    <= w_sel_err ? 4'd0 : w_be;
                r_mem_addr  <= w_sel_err ? '0 : {w_sel_addr[ADDR_W-1:2], 2'b00};
                r_mem_wdata <= w_sel_err ? 32'd0 : w_wdata;
            end
            if (r_state == S_ISSUE) begin
                r_mem_en    <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_be    <= 4'd0;
                r_mem_addr  <= '0;
                r_mem_wdata <= 32'd0;
            end
            if (r_state == S_RESP) begin
                if (r_own_dbg) begin
                    r_dbg_rvalid <= 1'b1;
                    r_dbg_rdata  <= w_resp_data;
                    r_dbg_err    <= r_err;
                end else begin
                    r_cpu_rvalid <= 1'b1;
                    r_cpu_rdata  <= w_resp_data;
                    r_cpu_err    <= r_err;
                end
            end
        end
    end

    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign cpu_err    = r_cpu_err;
    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;
    assign dbg_err    = r_dbg_err;
endmodule
